// File: rtl/mux_scan_n_if.sv
// Channel-mux bus: per-cycle controls and packed channel data in,
// registered selected data with its channel tag out.
interface mux_scan_n_if #(
    parameter int N_CH = 8,
    parameter int W    = 1
);
    localparam int SELW = (N_CH > 2) ? $clog2(N_CH) : 1;

    logic              en;
    logic              mode;
    logic [SELW-1:0]   sel;
    logic [N_CH*W-1:0] din;
    logic [W-1:0]      f;
    logic [SELW-1:0]   ch;
    logic              ch_valid;
    logic              wrap;

    modport master (output en, mode, sel, din, input f, ch, ch_valid, wrap);
    modport slave  (input en, mode, sel, din, output f, ch, ch_valid, wrap);
endinterface

// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit mux with manual select and a round-robin
// auto-scan that dwells DWELL enabled cycles on each channel.
module mux_scan_n #(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic         clk,
    input  logic         rst,
    mux_scan_n_if.slave  bus
);
    localparam int              SELW      = (N_CH > 2) ? $clog2(N_CH) : 1;
    localparam int              NPAD      = 1 << SELW;
    localparam logic [SELW-1:0] LAST      = SELW'(N_CH - 1);
    localparam logic [15:0]     DWELL_END = 16'(DWELL - 1);

    logic [SELW-1:0]           ch_q;
    logic [15:0]               dwell_q;
    logic [W-1:0]              f_q;
    logic                      valid_q;
    logic                      wrap_q;

    // Channel table padded to a power of two; unused slots read as zero.
    logic [NPAD-1:0][W-1:0]    chans;
    logic                      sel_ok;
    logic                      dwell_end;
    logic [SELW-1:0]           nxt_ch;

    always_comb begin
        chans = '0;
        for (int k = 0; k < N_CH; k++) chans[k] = bus.din[k*W +: W];
        sel_ok    = (32'(bus.sel) < N_CH);
        dwell_end = (dwell_q == DWELL_END);
        nxt_ch    = (ch_q == LAST) ? '0 : ch_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q    <= '0;
            dwell_q <= '0;
            f_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (!bus.en) begin
            // Scan position freezes; only the visible outputs go quiet.
            f_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (!bus.mode) begin
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            if (sel_ok) begin
                ch_q    <= bus.sel;
                f_q     <= chans[bus.sel];
                valid_q <= 1'b1;
            end else begin
                f_q     <= '0;
                valid_q <= 1'b0;
            end
        end else if (dwell_end) begin
            dwell_q <= '0;
            ch_q    <= nxt_ch;
            wrap_q  <= (ch_q == LAST);
            f_q     <= chans[nxt_ch];
            valid_q <= 1'b1;
        end else begin
            // Data is resampled every cycle of the dwell, not latched once.
            dwell_q <= dwell_q + 16'd1;
            wrap_q  <= 1'b0;
            f_q     <= chans[ch_q];
            valid_q <= 1'b1;
        end
    end

    assign bus.f        = f_q;
    assign bus.ch       = ch_q;
    assign bus.ch_valid = valid_q;
    assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: scan modelled as a position on a ring of
// N_CH*DWELL slots; expected outputs queued per edge, checked by a monitor.
module tb_mux_scan_n;
    localparam int N_CH  = 7;
    localparam int W     = 8;
    localparam int DWELL = 3;
    localparam int SELW  = 3;
    localparam int RING  = N_CH * DWELL;

    typedef struct {
        logic [W-1:0]    f;
        logic [SELW-1:0] ch;
        logic            v;
        logic            wrap;
        string           tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_scan_n_if #(.N_CH(N_CH), .W(W)) bus ();
    mux_scan_n #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   pos   = 0;   // ring slot: channel = pos / DWELL, dwell count = pos % DWELL
    bit   rnd_din = 1'b0;

    function automatic logic [W-1:0] chan(input int k);
        logic [N_CH*W-1:0] d;
        d = bus.din;
        return d[k*W +: W];
    endfunction

    task automatic step(input logic r, input logic e, input logic m,
                        input logic [SELW-1:0] s, input string tag);
        exp_t x;
        @(negedge clk);
        rst      = r;
        bus.en   = e;
        bus.mode = m;
        bus.sel  = s;
        if (rnd_din)
            for (int k = 0; k < N_CH; k++) bus.din[k*W +: W] = W'($urandom);
        @(posedge clk);
        x.tag = tag;
        if (r) begin
            pos = 0;
            x.f = '0; x.ch = '0; x.v = 1'b0; x.wrap = 1'b0;
        end else if (!e) begin
            x.f = '0; x.ch = SELW'(pos / DWELL); x.v = 1'b0; x.wrap = 1'b0;
        end else if (!m) begin
            x.wrap = 1'b0;
            if (int'(s) < N_CH) begin
                pos = int'(s) * DWELL;
                x.f = chan(int'(s)); x.ch = s; x.v = 1'b1;
            end else begin
                pos = (pos / DWELL) * DWELL;
                x.f = '0; x.ch = SELW'(pos / DWELL); x.v = 1'b0;
            end
        end else begin
            pos    = (pos + 1) % RING;
            x.ch   = SELW'(pos / DWELL);
            x.f    = chan(pos / DWELL);
            x.v    = 1'b1;
            x.wrap = (pos == 0);
        end
        q.push_back(x);
    endtask

    initial begin : mon
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                total++;
                if (bus.f !== x.f || bus.ch !== x.ch || bus.ch_valid !== x.v || bus.wrap !== x.wrap) begin
                    bad++;
                    $display("FAIL %s t=%0t: got f=%h ch=%0d v=%b wrap=%b, want f=%h ch=%0d v=%b wrap=%b",
                             x.tag, $time, bus.f, bus.ch, bus.ch_valid, bus.wrap, x.f, x.ch, x.v, x.wrap);
                end
            end
        end
    end

    initial begin : drv
        bit m;
        bus.en = 1'b0; bus.mode = 1'b0; bus.sel = '0;
        for (int k = 0; k < N_CH; k++) bus.din[k*W +: W] = W'(8'h10 + k);

        step(1, 0, 0, 0, "rst");
        step(1, 0, 0, 0, "rst");
        step(0, 1, 0, 3, "man_sel3");
        step(0, 1, 0, 6, "man_sel6");
        step(0, 1, 0, 0, "man_sel0");
        for (int i = 0; i < RING + 4; i++) step(0, 1, 1, 0, "auto_scan");

        step(0, 1, 0, 4, "oor_pre");
        step(0, 1, 0, 7, "oor_sel7");
        step(0, 1, 0, 7, "oor_sel7");
        for (int i = 0; i < 5; i++) step(0, 1, 1, 7, "oor_resume");

        step(0, 1, 0, 2, "frz_pre");
        step(0, 1, 1, 0, "frz_pre");
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, "frz_off");
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, "frz_resume");

        step(0, 1, 0, 6, "rstmid_pre");
        step(0, 1, 1, 0, "rstmid_pre");
        step(1, 1, 1, 0, "rstmid_rst");
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, "rstmid_scan");

        step(0, 1, 0, 4, "msw_pre");
        step(0, 1, 1, 0, "msw_pre");
        step(0, 1, 0, 1, "msw_man1");
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, "msw_auto");

        rnd_din = 1'b1;
        m = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0) m = ~m;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 99) < 85), m,
                 SELW'($urandom_range(0, 7)), "random");
        end

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d queued, want 0", q.size());
        end
        if (total < 12) begin
            bad++;
            $display("FAIL count: got %0d checks, want >= 12", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
